// File: rtl/vga_cursor_ctrl.sv
// Cursor-square position sequencer: manual single-step moves or autonomous bounce,
// with every position change committed only at frame start so no frame tears.
module vga_cursor_ctrl #(
  parameter int BOX       = 31,
  parameter int X_MIN     = 221,
  parameter int X_MAX     = 580 - BOX,
  parameter int Y_MIN     = 161,
  parameter int Y_MAX     = 440 - BOX,
  parameter int X_INIT    = 385,
  parameter int Y_INIT    = 285,
  parameter int STEP      = 4,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       auto_en,
  input  logic       req_valid,
  input  logic [1:0] req_dir,
  output logic       req_ready,
  output logic [9:0] cur_x,
  output logic [9:0] cur_y,
  output logic       upd_done
);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  localparam logic signed [10:0] XMN    = 11'(X_MIN);
  localparam logic signed [10:0] XMX    = 11'(X_MAX);
  localparam logic signed [10:0] YMN    = 11'(Y_MIN);
  localparam logic signed [10:0] YMX    = 11'(Y_MAX);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);

  state_t            state, state_nxt;
  logic [1:0]        pend_dir;
  logic              apply_auto;
  logic              dir_x_neg, dir_y_neg;
  logic [7:0]        div_cnt;

  logic signed [10:0] cx_s, cy_s, ax_raw, ay_raw;
  logic [9:0]         man_x, man_y, auto_x, auto_y;
  logic               auto_dx_neg, auto_dy_neg;

  function automatic logic [9:0] sat(input logic signed [10:0] v,
                                     input logic signed [10:0] lo,
                                     input logic signed [10:0] hi);
    if (v < lo)      return lo[9:0];
    else if (v > hi) return hi[9:0];
    else             return v[9:0];
  endfunction

  assign req_ready = (state == IDLE) && !auto_en;
  assign cx_s      = signed'({1'b0, cur_x});
  assign cy_s      = signed'({1'b0, cur_y});

  always_comb begin
    man_x = cur_x;
    man_y = cur_y;
    case (pend_dir)
      2'd0:    man_y = sat(cy_s - STEP_S, YMN, YMX);
      2'd1:    man_y = sat(cy_s + STEP_S, YMN, YMX);
      2'd2:    man_x = sat(cx_s - STEP_S, XMN, XMX);
      default: man_x = sat(cx_s + STEP_S, XMN, XMX);
    endcase
  end

  // Bounce: an overshoot clamps to the wall and reverses that axis only.
  always_comb begin
    ax_raw      = dir_x_neg ? cx_s - STEP_S : cx_s + STEP_S;
    ay_raw      = dir_y_neg ? cy_s - STEP_S : cy_s + STEP_S;
    auto_x      = sat(ax_raw, XMN, XMX);
    auto_y      = sat(ay_raw, YMN, YMX);
    auto_dx_neg = dir_x_neg;
    auto_dy_neg = dir_y_neg;
    if (ax_raw > XMX)      auto_dx_neg = 1'b1;
    else if (ax_raw < XMN) auto_dx_neg = 1'b0;
    if (ay_raw > YMX)      auto_dy_neg = 1'b1;
    else if (ay_raw < YMN) auto_dy_neg = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid && req_ready)
          state_nxt = PENDING;
        else if (auto_en && frame_start && div_cnt == DIV_LAST)
          state_nxt = APPLY;
      end
      PENDING: if (frame_start) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_x      <= 10'(X_INIT);
      cur_y      <= 10'(Y_INIT);
      upd_done   <= 1'b0;
      dir_x_neg  <= 1'b0;
      dir_y_neg  <= 1'b0;
      div_cnt    <= 8'd0;
      pend_dir   <= 2'd0;
      apply_auto <= 1'b0;
    end else begin
      state    <= state_nxt;
      upd_done <= 1'b0;
      // APPLY entered from IDLE is always an auto move; from PENDING, manual.
      apply_auto <= (state == IDLE);
      if (req_valid && req_ready)
        pend_dir <= req_dir;
      if (!auto_en)
        div_cnt <= 8'd0;
      else if (state == IDLE && frame_start)
        div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
      if (state == APPLY) begin
        upd_done <= 1'b1;
        if (apply_auto) begin
          cur_x     <= auto_x;
          cur_y     <= auto_y;
          dir_x_neg <= auto_dx_neg;
          dir_y_neg <= auto_dy_neg;
        end else begin
          cur_x <= man_x;
          cur_y <= man_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_cursor_ctrl.sv
// Bench for vga_cursor_ctrl: randomized manual and bounce traffic against a
// position/velocity model of the cursor square.
module tb_vga_cursor_ctrl;
  localparam int X_MIN = 221, X_MAX = 549, Y_MIN = 161, Y_MAX = 409;
  localparam int X_INIT = 385, Y_INIT = 285, STEP = 4;

  logic       clk = 1'b0;
  logic       rst, frame_start, auto_en, req_valid;
  logic [1:0] req_dir;
  logic       req_ready, upd_done;
  logic [9:0] cur_x, cur_y;

  int n_cmp = 0;
  int n_err = 0;
  int mx, my, vx, vy;

  always #5 clk = ~clk;

  vga_cursor_ctrl dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .auto_en(auto_en),
    .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
    .cur_x(cur_x), .cur_y(cur_y), .upd_done(upd_done)
  );

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic model_reset();
    mx = X_INIT; my = Y_INIT; vx = STEP; vy = STEP;
  endtask

  task automatic model_manual(input logic [1:0] d);
    case (d)
      2'd0: my = clampi(my - STEP, Y_MIN, Y_MAX);
      2'd1: my = clampi(my + STEP, Y_MIN, Y_MAX);
      2'd2: mx = clampi(mx - STEP, X_MIN, X_MAX);
      default: mx = clampi(mx + STEP, X_MIN, X_MAX);
    endcase
  endtask

  task automatic model_auto();
    int nx, ny;
    nx = mx + vx;
    ny = my + vy;
    if (nx > X_MAX) begin mx = X_MAX; vx = -STEP; end
    else if (nx < X_MIN) begin mx = X_MIN; vx = STEP; end
    else mx = nx;
    if (ny > Y_MAX) begin my = Y_MAX; vy = -STEP; end
    else if (ny < Y_MIN) begin my = Y_MIN; vy = STEP; end
    else my = ny;
  endtask

  // Applies frame_start, expects no change one edge later and the new model
  // position plus a single upd_done pulse on the second edge.
  task automatic frame_and_check(input bit is_auto, input logic [1:0] d);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk("early_upd", upd_done, 0);
    chk("early_x", cur_x, mx);
    cyc();
    if (is_auto) model_auto(); else model_manual(d);
    chk("new_x", cur_x, mx);
    chk("new_y", cur_y, my);
    chk("upd_pulse", upd_done, 1);
    cyc();
    chk("upd_clear", upd_done, 0);
    chk("x_stable", cur_x, mx);
  endtask

  task automatic manual_move(input logic [1:0] d, input int gap, input bit coincide);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_dir = d; frame_start = coincide;
    cyc();
    req_valid = 1'b0; frame_start = 1'b0;
    chk("ready_pend", req_ready, 0);
    for (int i = 0; i < gap; i++) begin
      req_valid = 1'($urandom);
      req_dir   = 2'($urandom);
      cyc();
    end
    req_valid = 1'b0;
    chk("hold_x", cur_x, mx);
    chk("hold_y", cur_y, my);
    chk("hold_upd", upd_done, 0);
    frame_and_check(1'b0, d);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; auto_en = 1'b0; req_valid = 1'b0; req_dir = 2'd0;
    model_reset();
    cyc();
    chk("rst_x", cur_x, X_INIT);
    chk("rst_y", cur_y, Y_INIT);
    chk("rst_upd", upd_done, 0);
    chk("rst_ready", req_ready, 1);
    cyc();
    rst = 1'b0;
    cyc();

    manual_move(2'd3, 100, 1'b0);
    chk("right_x", cur_x, 389);

    for (int i = 0; i < 45; i++) manual_move(2'd2, $urandom_range(1, 6), 1'b0);
    chk("left_clamp", cur_x, X_MIN);
    for (int i = 0; i < 35; i++) manual_move(2'd0, $urandom_range(1, 6), 1'b0);
    chk("up_clamp", cur_y, Y_MIN);

    for (int i = 0; i < 40; i++)
      manual_move(2'($urandom), $urandom_range(1, 8), 1'($urandom));

    manual_move(2'd1, 5, 1'b1);

    // Mode flipped to auto while a manual move waits: the manual move wins.
    req_valid = 1'b1; req_dir = 2'd3;
    cyc();
    req_valid = 1'b0; auto_en = 1'b1;
    repeat (3) cyc();
    frame_and_check(1'b0, 2'd3);
    chk("auto_ready", req_ready, 0);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(1, 5)) begin
        req_valid = 1'($urandom);
        cyc();
      end
      req_valid = 1'b0;
      frame_and_check(1'b1, 2'd0);
    end

    auto_en = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++)
      manual_move(2'($urandom), $urandom_range(1, 4), 1'b0);
    auto_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 4)) cyc();
      frame_and_check(1'b1, 2'd0);
    end
    auto_en = 1'b0;
    cyc();

    // Reset in the middle of a pending move discards it.
    req_valid = 1'b1; req_dir = 2'd3;
    cyc();
    req_valid = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_x", cur_x, mx);
    chk("midrst_y", cur_y, my);
    chk("midrst_upd", upd_done, 0);
    cyc();
    rst = 1'b0;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("postrst_upd", upd_done, 0);
      chk("postrst_x", cur_x, mx);
    end
    chk("postrst_ready", req_ready, 1);

    // Directions reset to +,+ so the first bounce tick moves down-right.
    auto_en = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) frame_and_check(1'b1, 2'd0);
    auto_en = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
